// File: rtl/strobe_capture_fifo.sv
// strobe_capture_fifo: captures data_in once per rising strobe into a small FIFO with sticky overflow.
module strobe_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stb_sync,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               cap_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic stb_d, cap, full, pop, push;
  always_comb begin
    cap = stb_sync & ~stb_d;
    full = level == LW'(DEPTH);
    out_valid = level != '0;
    pop = out_valid & out_ready;
    push = cap & (~full | pop);
    out_data = mem[rd_ptr];
  end
  // stb_d resets high so a strobe already asserted at reset release is ignored
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stb_d <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      cap_cnt <= '0;
    end else begin
      stb_d <= stb_sync;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        cap_cnt <= cap_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (cap && full && !pop) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
endmodule

// File: tb/tb_strobe_capture_fifo.sv
// tb_strobe_capture_fifo: directed scenario tests for strobe_capture_fifo.
module tb_strobe_capture_fifo;
  logic clk, rst, stb_sync, out_ready, out_valid, overflow;
  logic [7:0] data_in, out_data, cap_cnt;
  logic [2:0] level;
  int total, bad;

  strobe_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stb_sync(stb_sync), .data_in(data_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .level(level), .overflow(overflow), .cap_cnt(cap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    data_in = d;
    stb_sync = 1'b1;
    tick();
    stb_sync = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb_sync = 1'b0;
    out_ready = 1'b0;
    data_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string name, input logic [7:0] exp [], input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        bad++;
        $display("FAIL %s word%0d: got valid=%b data=%h, want valid=1 data=%h", name, i, out_valid, out_data, exp[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      bad++;
      $display("FAIL %s empty_after: got valid=%b level=%0d, want valid=0 level=0", name, out_valid, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stb_sync = 1'b0;
    out_ready = 1'b0;
    data_in = 8'h00;
    tick();
    total++;
    if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || cap_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: got level=%0d valid=%b ovf=%b cnt=%0d, want 0 0 0 0", level, out_valid, overflow, cap_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    data_in = 8'h55;
    stb_sync = 1'b1;
    tick();
    total++;
    if (level !== 3'd1 || out_valid !== 1'b1 || out_data !== 8'h55 || cap_cnt !== 8'd1) begin
      bad++;
      $display("FAIL single_capture: got level=%0d valid=%b data=%h cnt=%0d, want 1 1 55 1", level, out_valid, out_data, cap_cnt);
    end
    tick();
    tick();
    total++;
    if (level !== 3'd1 || cap_cnt !== 8'd1) begin
      bad++;
      $display("FAIL single_held: got level=%0d cnt=%0d, want 1 1", level, cap_cnt);
    end
    stb_sync = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop: got level=%0d valid=%b, want 0 0", level, out_valid);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp [] = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    for (int i = 1; i <= 5; i++) pulse(8'(i));
    total++;
    if (level !== 3'd4 || overflow !== 1'b1 || cap_cnt !== 8'd4) begin
      bad++;
      $display("FAIL fill_overflow: got level=%0d ovf=%b cnt=%0d, want 4 1 4", level, overflow, cap_cnt);
    end
    drain("fill_drain", exp, 4);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    total++;
    if (level !== 3'd0 || out_valid !== 1'b0 || cap_cnt !== 8'd4) begin
      bad++;
      $display("FAIL pop_empty: got level=%0d valid=%b cnt=%0d, want 0 0 4", level, out_valid, cap_cnt);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp [] = '{8'h11, 8'h12, 8'h13, 8'hAA};
    do_reset();
    for (int i = 0; i < 4; i++) pulse(8'h10 + 8'(i));
    total++;
    if (level !== 3'd4) begin
      bad++;
      $display("FAIL full_level: got %0d want 4", level);
    end
    data_in = 8'hAA;
    stb_sync = 1'b1;
    out_ready = 1'b1;
    tick();
    stb_sync = 1'b0;
    out_ready = 1'b0;
    total++;
    if (level !== 3'd4 || overflow !== 1'b0 || cap_cnt !== 8'd5) begin
      bad++;
      $display("FAIL full_pushpop: got level=%0d ovf=%b cnt=%0d, want 4 0 5", level, overflow, cap_cnt);
    end
    drain("pushpop_drain", exp, 4);
  endtask

  task automatic test_reset_strobe_high();
    rst = 1'b1;
    stb_sync = 1'b1;
    data_in = 8'h99;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (level !== 3'd0 || cap_cnt !== 8'd0) begin
      bad++;
      $display("FAIL strobe_high_release: got level=%0d cnt=%0d, want 0 0", level, cap_cnt);
    end
    stb_sync = 1'b0;
    tick();
    data_in = 8'h3C;
    stb_sync = 1'b1;
    tick();
    tick();
    stb_sync = 1'b0;
    total++;
    if (level !== 3'd1 || cap_cnt !== 8'd1 || out_data !== 8'h3C) begin
      bad++;
      $display("FAIL strobe_after_release: got level=%0d cnt=%0d data=%h, want 1 1 3c", level, cap_cnt, out_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) pulse(8'h20 + 8'(i));
    total++;
    if (level !== 3'd3) begin
      bad++;
      $display("FAIL async_pre_level: got %0d want 3", level);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || level !== 3'd0 || cap_cnt !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b level=%0d cnt=%0d, want 0 0 0", out_valid, level, cap_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    int rcv;
    rcv = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      data_in = 8'((i * 7 + 3) & 255);
      for (int k = 0; k < 2; k++) begin
        stb_sync = (k == 0);
        tick();
        if (out_valid) begin
          want = 8'((rcv * 7 + 3) & 255);
          total++;
          if (out_data !== want) begin
            bad++;
            $display("FAIL wrap_word%0d: got %h want %h", rcv, out_data, want);
          end
          rcv++;
        end
      end
    end
    out_ready = 1'b0;
    total++;
    if (rcv !== 260 || cap_cnt !== 8'd4 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL wrap_summary: got words=%0d cnt=%0d ovf=%b, want 260 4 0", rcv, cap_cnt, overflow);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pushpop();
    test_reset_strobe_high();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
